// File: rtl/sc_adder_chain_ctrl.sv
// Run controller for a stochastic-computing scaled-adder chain:
// sequences flush/run/drain, drives LFSR selects, counts output 1s.
module sc_adder_chain_ctrl #(
  parameter int          N         = 10,
  parameter int          LEN_W     = 8,
  parameter int          CHAIN_LAT = 1,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             sum_in,
  output logic             chain_rst,
  output logic             en,
  output logic [N-2:0]     sel,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] count
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FLUSH = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int DW = (CHAIN_LAT > 1) ? $clog2(CHAIN_LAT) : 1;

  logic [2:0]           state;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     run_cnt;
  logic [DW-1:0]        drain_cnt;
  logic [15:0]          lfsr;
  logic [15:0]          lfsr_nxt;
  logic [CHAIN_LAT-1:0] win_sr;
  logic                 win;

  assign lfsr_nxt  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign chain_rst = (state == FLUSH);
  assign en        = (state == RUN);
  assign sel       = en ? lfsr[N-2:0] : '0;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign win       = win_sr[CHAIN_LAT-1];

  // Window is en delayed by the chain latency, aligned with sum_in.
  always_ff @(posedge clk) begin
    if (rst || state == FLUSH) begin
      win_sr <= '0;
    end else begin
      win_sr <= (win_sr << 1) | CHAIN_LAT'(en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len_q     <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
      lfsr      <= SEED;
      count     <= '0;
    end else begin
      if (win && sum_in) begin
        count <= count + LEN_W'(1);
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= FLUSH;
            len_q <= len;
            lfsr  <= SEED;
            count <= '0;
          end
        end
        FLUSH: begin
          run_cnt   <= len_q - LEN_W'(1);
          drain_cnt <= DW'(CHAIN_LAT - 1);
          state     <= (len_q == '0) ? DRAIN : RUN;
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          if (run_cnt == '0) begin
            state <= DRAIN;
          end else begin
            run_cnt <= run_cnt - LEN_W'(1);
          end
        end
        DRAIN: begin
          if (drain_cnt == '0) begin
            state <= DONE;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sc_adder_chain_ctrl.sv
// Scenario bench for sc_adder_chain_ctrl: cycle-accurate
// expectations plus a count scoreboard popped at each done.
module tb_sc_adder_chain_ctrl;

  localparam int N     = 10;
  localparam int LEN_W = 8;
  localparam int CL    = 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             sum_in;
  logic             chain_rst;
  logic             en;
  logic [N-2:0]     sel;
  logic             busy;
  logic             done;
  logic [LEN_W-1:0] count;

  int n_cmp;
  int n_bad;
  int sb[$];

  sc_adder_chain_ctrl #(
    .N(N), .LEN_W(LEN_W), .CHAIN_LAT(CL), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .sum_in(sum_in), .chain_rst(chain_rst), .en(en),
    .sel(sel), .busy(busy), .done(done), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full run from the start cycle (0) through DONE (l+2+CL),
  // ending in the following IDLE cycle.
  task automatic do_run(input string nm, input int l,
                        input logic [63:0] mask, input int spulse);
    int          exp_c;
    int          last;
    int          got;
    logic [15:0] m;
    logic [N-2:0] e_sel;
    exp_c = 0;
    for (int c = 2 + CL; c <= l + 1 + CL; c++)
      if (mask[c]) exp_c++;
    sb.push_back(exp_c);
    m    = 16'hACE1;
    last = l + 2 + CL;
    len  = LEN_W'(l);
    for (int c = 0; c <= last; c++) begin
      start  = (c == 0) || (c == spulse);
      sum_in = mask[c];
      e_sel  = '0;
      if (c >= 2 && c <= l + 1) e_sel = m[N-2:0];
      n_cmp++;
      if (en !== (c >= 2 && c <= l + 1)) begin
        $display("FAIL %s en c=%0d got=%b want=%b", nm, c, en, !en);
        n_bad++;
      end
      n_cmp++;
      if (done !== (c == last)) begin
        $display("FAIL %s done c=%0d got=%b want=%b", nm, c, done, c == last);
        n_bad++;
      end
      n_cmp++;
      if (busy !== (c >= 1)) begin
        $display("FAIL %s busy c=%0d got=%b want=%b", nm, c, busy, c >= 1);
        n_bad++;
      end
      n_cmp++;
      if (chain_rst !== (c == 1)) begin
        $display("FAIL %s chain_rst c=%0d got=%b want=%b", nm, c, chain_rst, c == 1);
        n_bad++;
      end
      n_cmp++;
      if (sel !== e_sel) begin
        $display("FAIL %s sel c=%0d got=%h want=%h", nm, c, sel, e_sel);
        n_bad++;
      end
      if (done === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin
          $display("FAIL %s count_sb got=%0d want=<empty>", nm, count);
          n_bad++;
        end else begin
          got = sb.pop_front();
          if (count !== LEN_W'(got)) begin
            $display("FAIL %s count got=%0d want=%0d", nm, count, got);
            n_bad++;
          end
        end
      end
      if (c >= 2 && c <= l + 1)
        m = {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
      tick();
    end
    start  = 1'b0;
    sum_in = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || count !== LEN_W'(exp_c)) begin
      $display("FAIL %s idle_after busy=%b count=%0d want busy=0 count=%0d",
               nm, busy, count, exp_c);
      n_bad++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; sum_in = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({chain_rst, en, sel, busy, done, count} !== '0) begin
        $display("FAIL reset outs got=%b%b%h%b%b%h want=all0",
                 chain_rst, en, sel, busy, done, count);
        n_bad++;
      end
    end
    rst = 1'b0;
    do_run("reset_then_start", 3, 64'hFFFF_FFFF_FFFF_FFFF, -1);
  endtask

  task automatic test_basic();
    do_run("basic_len4", 4, 64'hFFFF_FFFF_FFFF_FFFF, -1);
  endtask

  task automatic test_window();
    do_run("win_outside", 4, 64'h84, -1);
    do_run("win_inside", 4, 64'h48, -1);
  endtask

  task automatic test_sel();
    do_run("sel_run1", 6, 64'h0, -1);
    do_run("sel_run2", 6, 64'h2A5, -1);
  endtask

  task automatic test_len0();
    do_run("len0", 0, 64'hFFFF_FFFF_FFFF_FFFF, -1);
  endtask

  task automatic test_protocol();
    do_run("start_in_run", 5, 64'h1F0, 4);
    len = 8'd10; start = 1'b1; sum_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({busy, en, sel, done, count, chain_rst} !== '0) begin
      $display("FAIL rst_midrun outs busy=%b en=%b sel=%h done=%b count=%0d",
               busy, en, sel, done, count);
      n_bad++;
    end
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (done !== 1'b0 || en !== 1'b0) begin
        $display("FAIL rst_nodone i=%0d done=%b en=%b want=0", i, done, en);
        n_bad++;
      end
      tick();
    end
    sum_in = 1'b0;
    do_run("after_abort_len2", 2, 64'hC, -1);
  endtask

  task automatic test_back_to_back();
    do_run("b2b_a", 3, 64'h30, -1);
    do_run("b2b_b", 5, 64'hFFFF_FFFF_FFFF_FFFF, -1);
    do_run("b2b_c", 1, 64'h8, -1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_basic();
    test_window();
    test_sel();
    test_len0();
    test_protocol();
    test_back_to_back();
    n_cmp++;
    if (sb.size() != 0) begin
      $display("FAIL sb_drained got=%0d want=0", sb.size());
      n_bad++;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
